// File: rtl/uds_tile_feeder.sv
// Purpose: packs a 32-bit word stream into A-word tiles through two ping-pong buffers and sequences the UDS load/compute handshake per tile.
// Latency: the last word of a tile accepted at edge N gives idata_valid after N+1, active after N+2 and active low after N+3.
// Backpressure: in_ready is low when the fill buffer is still full, when the frame tile count has been accepted, or when no frame is running.
module uds_tile_feeder #(
    parameter int A    = 64,
    parameter int NT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NT_W-1:0]   num_tiles,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [A*32-1:0]   idata,
    output logic              idata_valid,
    output logic              active,
    output logic              busy,
    output logic              done
);

    localparam int WC_W = $clog2(A);
    localparam int BB_W = WC_W + 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_HOLD
    } state_t;

    logic [A*32-1:0] tbuf [2];
    logic [1:0]      full_q;
    logic            fill_ptr;
    logic            iss_ptr;
    logic [WC_W-1:0] wcnt;
    logic [NT_W-1:0] nt_q;
    logic [NT_W-1:0] acc_q;
    logic [NT_W-1:0] iss_q;
    logic            busy_q;
    logic            done_q;
    logic [A*32-1:0] idata_q;
    state_t          state_q;
    state_t          state_d;
    logic            load;

    logic            start_ok;
    logic            wr;
    logic            last_word;
    logic            rel;
    logic            final_tile;
    logic [BB_W-1:0] wbase;

    // A new frame may only begin once the previous one has fully retired.
    assign start_ok   = start & ~busy_q & ~done_q;
    assign in_ready   = busy_q & ~full_q[fill_ptr] & (acc_q < nt_q);
    assign wr         = in_valid & in_ready;
    assign last_word  = wr && (wcnt == WC_W'(A - 1));
    assign rel        = (state_q == S_COMP);
    assign final_tile = rel && ((iss_q + NT_W'(1)) == nt_q);
    assign wbase      = {wcnt, 5'b0};

    assign idata       = idata_q;
    assign idata_valid = (state_q == S_LOAD);
    assign active      = (state_q == S_COMP);
    assign busy        = busy_q;
    assign done        = done_q;

    // Tile storage: data only, every slot is rewritten before a buffer is marked full.
    always_ff @(posedge clk) begin
        if (wr) begin
            tbuf[fill_ptr][wbase +: 32] <= in_data;
        end
    end

    // Frame control, fill side and buffer ownership flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 2'b00;
            fill_ptr <= 1'b0;
            iss_ptr  <= 1'b0;
            wcnt     <= '0;
            nt_q     <= '0;
            acc_q    <= '0;
            iss_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                nt_q     <= num_tiles;
                acc_q    <= '0;
                iss_q    <= '0;
                fill_ptr <= 1'b0;
                iss_ptr  <= 1'b0;
                wcnt     <= '0;
                full_q   <= 2'b00;
                if (num_tiles == '0) begin
                    done_q <= 1'b1;
                end else begin
                    busy_q <= 1'b1;
                end
            end else begin
                if (wr) begin
                    if (last_word) begin
                        wcnt             <= '0;
                        full_q[fill_ptr] <= 1'b1;
                        fill_ptr         <= ~fill_ptr;
                        acc_q            <= acc_q + NT_W'(1);
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                // Release always targets the buffer opposite the one being filled.
                if (rel) begin
                    full_q[iss_ptr] <= 1'b0;
                    iss_ptr         <= ~iss_ptr;
                    iss_q           <= iss_q + NT_W'(1);
                    if (final_tile) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue FSM next state; HOLD chains straight into LOAD when the other buffer is ready.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[iss_ptr]) begin
                    state_d = S_LOAD;
                    load    = 1'b1;
                end
            end
            S_LOAD: state_d = S_COMP;
            S_COMP: state_d = S_HOLD;
            S_HOLD: begin
                if (full_q[iss_ptr]) begin
                    state_d = S_LOAD;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tile bus register: captured on entry to LOAD, held until the next tile loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idata_q <= '0;
        end else if (load) begin
            idata_q <= tbuf[iss_ptr];
        end
    end

endmodule
